// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with registered occupancy count and status flags.
// Supports registered-read and first-word-fall-through read modes.
module sync_fifo_flags #(
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 16,
   parameter int PTR_WIDTH  = 4,
   parameter int AFULL_THR  = DEPTH - 2,
   parameter int AEMPTY_THR = 2,
   parameter int FWFT       = 0
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 wr_en_i,
   input  logic [WIDTH-1:0]     wdata_i,
   output logic                 full_o,
   output logic                 almost_full_o,
   output logic                 wr_error_o,
   input  logic                 rd_en_i,
   output logic [WIDTH-1:0]     rdata_o,
   output logic                 rvalid_o,
   output logic                 empty_o,
   output logic                 almost_empty_o,
   output logic                 rd_error_o,
   output logic [PTR_WIDTH:0]   count_o
);

   localparam logic [PTR_WIDTH:0] FULL_CNT = (PTR_WIDTH+1)'(DEPTH);
   localparam logic [PTR_WIDTH:0] AF_CNT   = (PTR_WIDTH+1)'(AFULL_THR);
   localparam logic [PTR_WIDTH:0] AE_CNT   = (PTR_WIDTH+1)'(AEMPTY_THR);
   localparam logic [PTR_WIDTH:0] ONE      = (PTR_WIDTH+1)'(1);

   logic [WIDTH-1:0]   mem [DEPTH];
   logic [PTR_WIDTH:0] wr_ptr;
   logic [PTR_WIDTH:0] rd_ptr;
   logic [PTR_WIDTH:0] count;
   logic               wr_acc;
   logic               rd_acc;
   logic               unused_wrap;

   // Wrap bits are kept for pointer bookkeeping; flags come from count.
   assign unused_wrap = ^{wr_ptr[PTR_WIDTH], rd_ptr[PTR_WIDTH]};

   assign empty_o        = (count == '0);
   assign full_o         = (count == FULL_CNT);
   assign almost_full_o  = (count >= AF_CNT);
   assign almost_empty_o = (count <= AE_CNT);
   assign count_o        = count;

   assign rd_acc = rd_en_i & ~empty_o;
   assign wr_acc = wr_en_i & (~full_o | rd_acc);

   always_ff @(posedge clk_i) begin
      if (wr_acc)
         mem[wr_ptr[PTR_WIDTH-1:0]] <= wdata_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         wr_error_o <= 1'b0;
         rd_error_o <= 1'b0;
      end else begin
         wr_error_o <= wr_en_i & ~wr_acc;
         rd_error_o <= rd_en_i & ~rd_acc;
         if (wr_acc)
            wr_ptr <= wr_ptr + ONE;
         if (rd_acc)
            rd_ptr <= rd_ptr + ONE;
         unique case ({wr_acc, rd_acc})
            2'b10:   count <= count + ONE;
            2'b01:   count <= count - ONE;
            default: count <= count;
         endcase
      end
   end

   if (FWFT != 0) begin : g_fwft
      assign rdata_o  = mem[rd_ptr[PTR_WIDTH-1:0]];
      assign rvalid_o = ~empty_o;
   end else begin : g_reg
      logic [WIDTH-1:0] rdata_q;
      logic             rvalid_q;

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
         end else begin
            rvalid_q <= rd_acc;
            if (rd_acc)
               rdata_q <= mem[rd_ptr[PTR_WIDTH-1:0]];
         end
      end

      assign rdata_o  = rdata_q;
      assign rvalid_o = rvalid_q;
   end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: registered-read and FWFT instances share
// stimulus and are compared against a queue-based reference model.
module tb_sync_fifo_flags;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_en;
   logic       rd_en;
   logic [7:0] wdata;

   logic       full0, afull0, werr0, rvalid0, empty0, aempty0, rerr0;
   logic [7:0] rdata0;
   logic [4:0] cnt0;
   logic       full1, afull1, werr1, rvalid1, empty1, aempty1, rerr1;
   logic [7:0] rdata1;
   logic [4:0] cnt1;

   int compared   = 0;
   int mismatched = 0;

   // reference model state
   byte unsigned q[$];
   logic [7:0]   m_rd0;
   logic         m_rv0;
   logic         m_werr;
   logic         m_rerr;

   always #5 clk = ~clk;

   sync_fifo_flags #(.FWFT(0)) dut0 (
      .clk_i(clk), .rst_i(rst),
      .wr_en_i(wr_en), .wdata_i(wdata),
      .full_o(full0), .almost_full_o(afull0), .wr_error_o(werr0),
      .rd_en_i(rd_en), .rdata_o(rdata0), .rvalid_o(rvalid0),
      .empty_o(empty0), .almost_empty_o(aempty0), .rd_error_o(rerr0),
      .count_o(cnt0)
   );

   sync_fifo_flags #(.FWFT(1)) dut1 (
      .clk_i(clk), .rst_i(rst),
      .wr_en_i(wr_en), .wdata_i(wdata),
      .full_o(full1), .almost_full_o(afull1), .wr_error_o(werr1),
      .rd_en_i(rd_en), .rdata_o(rdata1), .rvalid_o(rvalid1),
      .empty_o(empty1), .almost_empty_o(aempty1), .rd_error_o(rerr1),
      .count_o(cnt1)
   );

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      int n;
      n = q.size();
      chk("count0", 32'(cnt0), n);
      chk("count1", 32'(cnt1), n);
      chk("full0", 32'(full0), 32'(n == 16));
      chk("full1", 32'(full1), 32'(n == 16));
      chk("afull0", 32'(afull0), 32'(n >= 14));
      chk("afull1", 32'(afull1), 32'(n >= 14));
      chk("empty0", 32'(empty0), 32'(n == 0));
      chk("empty1", 32'(empty1), 32'(n == 0));
      chk("aempty0", 32'(aempty0), 32'(n <= 2));
      chk("aempty1", 32'(aempty1), 32'(n <= 2));
      chk("werr0", 32'(werr0), 32'(m_werr));
      chk("werr1", 32'(werr1), 32'(m_werr));
      chk("rerr0", 32'(rerr0), 32'(m_rerr));
      chk("rerr1", 32'(rerr1), 32'(m_rerr));
      chk("rvalid0", 32'(rvalid0), 32'(m_rv0));
      chk("rdata0", 32'(rdata0), 32'(m_rd0));
      chk("rvalid1", 32'(rvalid1), 32'(n > 0));
      if (n > 0)
         chk("rdata1", 32'(rdata1), 32'(q[0]));
   endtask

   task automatic model_reset();
      q.delete();
      m_rd0  = 8'h00;
      m_rv0  = 1'b0;
      m_werr = 1'b0;
      m_rerr = 1'b0;
   endtask

   task automatic step(logic w, logic [7:0] d, logic r);
      bit rok;
      bit wok;
      wr_en = w;
      wdata = d;
      rd_en = r;
      @(posedge clk);
      rok    = r && (q.size() > 0);
      wok    = w && (q.size() < 16 || rok);
      m_rerr = r && !rok;
      m_werr = w && !wok;
      m_rv0  = rok;
      if (rok)
         m_rd0 = q.pop_front();
      if (wok)
         q.push_back(d);
      #1;
      check_all();
   endtask

   initial begin
      int pw;
      rst   = 1'b1;
      wr_en = 1'b0;
      rd_en = 1'b0;
      wdata = 8'h00;
      model_reset();
      #1;
      check_all();
      #11;
      rst = 1'b0;

      // fill to full, then one rejected write
      for (int i = 1; i <= 16; i++)
         step(1'b1, 8'(i), 1'b0);
      step(1'b1, 8'h11, 1'b0);
      step(1'b0, 8'h00, 1'b0);

      // drain in order, then one rejected read
      for (int i = 0; i < 16; i++)
         step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b0);

      // full with simultaneous traffic across pointer wrap
      for (int i = 0; i < 16; i++)
         step(1'b1, 8'($urandom), 1'b0);
      for (int i = 0; i < 20; i++)
         step(1'b1, 8'($urandom), 1'b1);
      for (int i = 0; i < 16; i++)
         step(1'b0, 8'h00, 1'b1);

      // simultaneous write and read while empty
      step(1'b1, 8'hAA, 1'b1);
      step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b1);

      // asynchronous reset mid-cycle with data stored
      for (int i = 0; i < 5; i++)
         step(1'b1, 8'(8'h30 + i), 1'b0);
      wr_en = 1'b1;
      rd_en = 1'b1;
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check_all();
      @(posedge clk);
      #1;
      check_all();
      #3;
      rst   = 1'b0;
      wr_en = 1'b0;
      rd_en = 1'b0;
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b0);

      // randomized traffic with shifting write bias
      for (int ph = 0; ph < 3; ph++) begin
         pw = 75 - 25 * ph;
         for (int i = 0; i < 150; i++)
            step($urandom_range(99) < pw, 8'($urandom),
                 $urandom_range(99) < 50);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
